// File: rtl/frame_minmax_pkg.sv
// Shared helpers and constants for the frame_minmax block.
// frame_sum (enabled by FRAME_MINMAX_SUM_EN) is sized with sum_w().
package frame_minmax_pkg;

    typedef enum logic {StFirst, StAccum} phase_e;

    localparam int unsigned RST_WORD = 0;
    localparam logic        RST_FLAG = 1'b0;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned sum_w(input int unsigned w, input int unsigned frame_len);
        return w + $clog2(2 * frame_len) + 1;
    endfunction

endpackage

// File: rtl/minmax_acc.sv
// Registered running max/min accumulator with first-load, update and hold controls.
// o_next_* is the value the accumulator takes when loaded/updated this cycle.
module minmax_acc
    import frame_minmax_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load_first,
    input  logic             i_update,
    input  logic [width-1:0] i_largest,
    input  logic [width-1:0] i_smallest,
    output logic [width-1:0] o_next_max,
    output logic [width-1:0] o_next_min
);

    logic [width-1:0] r_acc_max;
    logic [width-1:0] r_acc_min;

    always_comb begin
        o_next_max = i_largest;
        o_next_min = i_smallest;
        if (!i_load_first) begin
            o_next_max = (i_largest > r_acc_max) ? i_largest : r_acc_max;
            o_next_min = (i_smallest < r_acc_min) ? i_smallest : r_acc_min;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc_max <= width'(RST_WORD);
            r_acc_min <= width'(RST_WORD);
        end else if (i_load_first || i_update) begin
            r_acc_max <= o_next_max;
            r_acc_min <= o_next_min;
        end
    end

endmodule

// File: rtl/frame_minmax.sv
// Per-frame max/min of a largest/smallest pair stream with a valid/ready result register.
// Define FRAME_MINMAX_SUM_EN to add the frame_sum output (sum of both words over the frame).
module frame_minmax
    import frame_minmax_pkg::*;
#(
    parameter int unsigned width     = 8,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [width-1:0] largest_in,
    input  logic [width-1:0] smallest_in,
    output logic [width-1:0] frame_max,
    output logic [width-1:0] frame_min,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_active,
    output logic             overflow
`ifdef FRAME_MINMAX_SUM_EN
    ,
    output logic [sum_w(width, FRAME_LEN)-1:0] frame_sum
`endif
);

    localparam int unsigned      CNT_W = clog2_min1(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] r_count;
    logic [width-1:0] r_frame_max;
    logic [width-1:0] r_frame_min;
    logic             r_out_valid;
    logic             r_overflow;

    phase_e           w_phase;
    logic             w_take;
    logic             w_first;
    logic             w_accum;
    logic             w_last;
    logic             w_xfer;
    logic [width-1:0] w_next_max;
    logic [width-1:0] w_next_min;

    // clr wins over the sample: a pair presented alongside clr is dropped.
    assign w_phase = (r_count == '0) ? StFirst : StAccum;
    assign w_take  = in_valid && !clr;
    assign w_first = w_take && (w_phase == StFirst);
    assign w_accum = w_take && (w_phase == StAccum);
    assign w_last  = w_take && (r_count == LAST);
    assign w_xfer  = r_out_valid && out_ready;

    minmax_acc #(
        .width(width)
    ) u_acc (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_load_first(w_first),
        .i_update    (w_accum),
        .i_largest   (largest_in),
        .i_smallest  (smallest_in),
        .o_next_max  (w_next_max),
        .o_next_min  (w_next_min)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_take) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    // Result register; a completion landing on an unaccepted result overwrites it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_max <= width'(RST_WORD);
            r_frame_min <= width'(RST_WORD);
            r_out_valid <= RST_FLAG;
            r_overflow  <= RST_FLAG;
        end else if (clr) begin
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_last) begin
            r_frame_max <= w_next_max;
            r_frame_min <= w_next_min;
            r_out_valid <= 1'b1;
            if (r_out_valid && !out_ready) begin
                r_overflow <= 1'b1;
            end
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef FRAME_MINMAX_SUM_EN
    localparam int unsigned SUM_W = sum_w(width, FRAME_LEN);

    logic [SUM_W-1:0] r_acc_sum;
    logic [SUM_W-1:0] r_frame_sum;
    logic [SUM_W-1:0] w_next_sum;

    assign w_next_sum = ((w_phase == StFirst) ? '0 : r_acc_sum)
                      + SUM_W'(largest_in) + SUM_W'(smallest_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_sum   <= SUM_W'(RST_WORD);
            r_frame_sum <= SUM_W'(RST_WORD);
        end else if (w_take) begin
            r_acc_sum <= w_next_sum;
            if (w_last) begin
                r_frame_sum <= w_next_sum;
            end
        end
    end

    assign frame_sum = r_frame_sum;
`endif

    assign frame_max    = r_frame_max;
    assign frame_min    = r_frame_min;
    assign out_valid    = r_out_valid;
    assign overflow     = r_overflow;
    assign frame_active = (r_count != '0);

endmodule

// File: tb/tb_frame_minmax.sv
// Scoreboard bench for frame_minmax: FRAME_LEN=4 and FRAME_LEN=1 instances share one stimulus.
// Honours FRAME_MINMAX_SUM_EN to also check frame_sum.
module tb_frame_minmax;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] largest_in;
    logic [W-1:0] smallest_in;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        int unsigned mx;
        int unsigned mn;
        int unsigned sm;
    } res_t;

    always #5 clk = ~clk;

    task automatic check(input string nm, input int inst, input int unsigned act,
                         input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[inst%0d] t=%0t: got 0x%0h, want 0x%0h", nm, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned FL = (g == 0) ? 4 : 1;

        logic [W-1:0] frame_max;
        logic [W-1:0] frame_min;
        logic         out_valid;
        logic         frame_active;
        logic         overflow;
`ifdef FRAME_MINMAX_SUM_EN
        logic [frame_minmax_pkg::sum_w(W, FL)-1:0] frame_sum;
`endif

        frame_minmax #(
            .width    (W),
            .FRAME_LEN(FL)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .clr         (clr),
            .in_valid    (in_valid),
            .largest_in  (largest_in),
            .smallest_in (smallest_in),
            .frame_max   (frame_max),
            .frame_min   (frame_min),
            .out_valid   (out_valid),
            .out_ready   (out_ready),
            .frame_active(frame_active),
`ifdef FRAME_MINMAX_SUM_EN
            .frame_sum   (frame_sum),
`endif
            .overflow    (overflow)
        );

        res_t        q[$];
        int unsigned fr_l[$];
        int unsigned fr_s[$];
        bit          exp_ovf = 1'b0;

        // Reference model: collect a frame's pairs, reduce them once the frame is full.
        initial forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                fr_l.delete();
                fr_s.delete();
                exp_ovf = 1'b0;
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (clr) begin
                    q.delete();
                    fr_l.delete();
                    fr_s.delete();
                    exp_ovf = 1'b0;
                end else if (in_valid) begin
                    fr_l.push_back(int'(largest_in));
                    fr_s.push_back(int'(smallest_in));
                    if (fr_l.size() == FL) begin
                        res_t r;
                        r.mx = 0;
                        r.mn = 255;
                        r.sm = 0;
                        foreach (fr_l[i]) begin
                            if (fr_l[i] > r.mx) r.mx = fr_l[i];
                            if (fr_s[i] < r.mn) r.mn = fr_s[i];
                            r.sm += fr_l[i] + fr_s[i];
                        end
                        if (q.size() != 0) begin
                            q[0]    = r;
                            exp_ovf = 1'b1;
                        end else begin
                            q.push_back(r);
                        end
                        fr_l.delete();
                        fr_s.delete();
                    end
                end
            end
        end

        initial forever begin
            @(negedge clk);
            check("out_valid", g, int'(out_valid), int'(q.size() != 0));
            check("overflow", g, int'(overflow), int'(exp_ovf));
            check("frame_active", g, int'(frame_active), int'(fr_l.size() != 0));
            if (q.size() != 0) begin
                check("frame_max", g, int'(frame_max), q[0].mx);
                check("frame_min", g, int'(frame_min), q[0].mn);
`ifdef FRAME_MINMAX_SUM_EN
                check("frame_sum", g, int'(frame_sum), q[0].sm);
`endif
            end
        end
    end

    task automatic step(input logic v, input int unsigned l, input int unsigned s);
        in_valid    = v;
        largest_in  = W'(l);
        smallest_in = W'(s);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic frame4(input int unsigned l0, s0, l1, s1, l2, s2, l3, s3, input int gap);
        step(1'b1, l0, s0);
        idle(gap < 0 ? $urandom_range(0, 5) : gap);
        step(1'b1, l1, s1);
        idle(gap < 0 ? $urandom_range(0, 5) : gap);
        step(1'b1, l2, s2);
        idle(gap < 0 ? $urandom_range(0, 5) : gap);
        step(1'b1, l3, s3);
    endtask

    task automatic expect0(input int unsigned v, mx, mn, ovf);
        check("dir_valid", 0, int'(g_inst[0].out_valid), v);
        check("dir_max", 0, int'(g_inst[0].frame_max), mx);
        check("dir_min", 0, int'(g_inst[0].frame_min), mn);
        check("dir_ovf", 0, int'(g_inst[0].overflow), ovf);
    endtask

    initial begin
        rst         = 1'b0;
        clr         = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        largest_in  = '0;
        smallest_in = '0;
        #3;
        expect0(0, 0, 0, 0);
        check("rst_active", 0, int'(g_inst[0].frame_active), 0);
        idle(2);
        rst = 1'b1;
        idle(1);

        // Basic frame, then out_valid for exactly one cycle
        frame4(9, 3, 200, 7, 50, 1, 12, 90, 0);
        expect0(1, 200, 1, 0);
`ifdef FRAME_MINMAX_SUM_EN
        check("dir_sum", 0, int'(g_inst[0].frame_sum), 372);
`endif
        idle(1);
        check("dir_valid_drop", 0, int'(g_inst[0].out_valid), 0);

        // Same frame with gaps between pairs
        do_clr();
        frame4(9, 3, 200, 7, 50, 1, 12, 90, -1);
        expect0(1, 200, 1, 0);
        idle(3);

        // Two frames with no acceptance: second overwrites and sets overflow
        do_clr();
        out_ready = 1'b0;
        frame4(100, 2, 3, 4, 5, 6, 7, 8, 1);
        frame4(77, 5, 30, 20, 60, 9, 10, 40, 0);
        expect0(1, 77, 5, 1);
        idle(3);
        expect0(1, 77, 5, 1);
        out_ready = 1'b1;
        idle(1);
        expect0(0, 77, 5, 1);
        idle(2);
        check("ovf_sticky", 0, int'(g_inst[0].overflow), 1);
        do_clr();
        check("ovf_clr", 0, int'(g_inst[0].overflow), 0);

        // clr mid-frame, with a pair presented on the clr cycle
        step(1'b1, 250, 0);
        step(1'b1, 240, 0);
        clr = 1'b1;
        step(1'b1, 255, 0);
        clr = 1'b0;
        check("clr_active", 0, int'(g_inst[0].frame_active), 0);
        frame4(10, 4, 7, 6, 10, 5, 8, 4, 0);
        expect0(1, 10, 4, 0);
        idle(2);

        // FRAME_LEN=1 back-to-back results
        do_clr();
        step(1'b1, 8'hFF, 8'h00);
        check("fl1_valid", 1, int'(g_inst[1].out_valid), 1);
        check("fl1_max", 1, int'(g_inst[1].frame_max), 32'hFF);
        check("fl1_min", 1, int'(g_inst[1].frame_min), 32'h00);
        step(1'b1, 8'h80, 8'h80);
        check("fl1_valid2", 1, int'(g_inst[1].out_valid), 1);
        check("fl1_max2", 1, int'(g_inst[1].frame_max), 32'h80);
        check("fl1_min2", 1, int'(g_inst[1].frame_min), 32'h80);
        check("fl1_ovf", 1, int'(g_inst[1].overflow), 0);
        idle(2);

        // Asynchronous reset while a result is pending and a frame is half full
        do_clr();
        out_ready = 1'b0;
        frame4(1, 1, 2, 2, 3, 3, 4, 4, 0);
        step(1'b1, 20, 10);
        step(1'b1, 30, 15);
        #2;
        rst = 1'b0;
        #1;
        expect0(0, 0, 0, 0);
        check("rst_active_mid", 0, int'(g_inst[0].frame_active), 0);
        check("rst_valid1", 1, int'(g_inst[1].out_valid), 0);
        check("rst_max1", 1, int'(g_inst[1].frame_max), 0);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        frame4(60, 33, 61, 34, 59, 35, 58, 36, 0);
        expect0(1, 61, 33, 0);
        idle(2);

        // Randomised traffic with backpressure and occasional clr
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 59) == 0);
            step(($urandom_range(0, 2) != 0), $urandom_range(0, 255), $urandom_range(0, 255));
            clr = 1'b0;
        end
        out_ready = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
